// File: rtl/mbo_uart_tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mbo_uart_tx_framer
//  Function : Payload FIFO plus frame sequencer (HEADER, LEN, payload, XOR
//             checksum) feeding a UART transmitter byte handshake.
//  Revision : 1.0  initial release
// ============================================================================
module mbo_uart_tx_framer #(
   parameter int         ADDR_W = 4,
   parameter logic [7:0] HEADER = 8'hA5
) (
   input  logic       i_Clock,
   input  logic       rst,
   input  logic       i_Wr_En,
   input  logic [7:0] i_Wr_Data,
   input  logic       i_Send,
   input  logic       i_Tx_Active,
   input  logic       i_Tx_Done,
   output logic       o_Tx_DV,
   output logic [7:0] o_Tx_Byte,
   output logic       o_Full,
   output logic       o_Empty,
   output logic       o_Busy,
   output logic       o_Frame_Done,
   output logic       o_Overflow
);

   localparam int              c_DEPTH_N = 1 << ADDR_W;
   localparam logic [ADDR_W:0] c_DEPTH   = {1'b1, {ADDR_W{1'b0}}};

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_ISSUE = 2'd1;
   localparam logic [1:0] c_ST_WAIT  = 2'd2;

   localparam logic [1:0] c_PH_HDR  = 2'd0;
   localparam logic [1:0] c_PH_LEN  = 2'd1;
   localparam logic [1:0] c_PH_DATA = 2'd2;
   localparam logic [1:0] c_PH_CSUM = 2'd3;

   logic [7:0]        r_Mem [0:c_DEPTH_N-1];
   logic [ADDR_W-1:0] r_Wr_Ptr;
   logic [ADDR_W-1:0] r_Rd_Ptr;
   logic [ADDR_W:0]   r_Count;
   logic              r_Full;
   logic              r_Empty;
   logic              r_Overflow;

   logic [1:0]        r_State;
   logic [1:0]        r_Phase;
   logic [7:0]        r_Len;
   logic [7:0]        r_Remain;
   logic [7:0]        r_Csum;
   logic              r_Tx_DV;
   logic [7:0]        r_Tx_Byte;
   logic              r_Busy;
   logic              r_Frame_Done;

   logic              w_Wr_Accept;
   logic              w_Rd;
   logic [ADDR_W:0]   w_Count_Next;
   logic [7:0]        w_Rd_Data;
   logic [7:0]        w_Occ;

   // Full is the registered flag, so a same-cycle read never frees a slot.
   assign w_Wr_Accept  = i_Wr_En & ~r_Full;
   assign w_Rd         = (r_State == c_ST_ISSUE) && (r_Phase == c_PH_DATA) && !i_Tx_Active;
   assign w_Count_Next = r_Count + (ADDR_W+1)'(w_Wr_Accept) - (ADDR_W+1)'(w_Rd);
   assign w_Rd_Data    = r_Mem[r_Rd_Ptr];
   assign w_Occ        = 8'(r_Count);

   always_ff @(posedge i_Clock) begin
      if (w_Wr_Accept) begin
         r_Mem[r_Wr_Ptr] <= i_Wr_Data;
      end
   end

   always_ff @(posedge i_Clock or posedge rst) begin
      if (rst) begin
         r_Wr_Ptr   <= '0;
         r_Rd_Ptr   <= '0;
         r_Count    <= '0;
         r_Full     <= 1'b0;
         r_Empty    <= 1'b1;
         r_Overflow <= 1'b0;
      end else begin
         if (w_Wr_Accept) begin
            r_Wr_Ptr <= r_Wr_Ptr + ADDR_W'(1);
         end
         if (w_Rd) begin
            r_Rd_Ptr <= r_Rd_Ptr + ADDR_W'(1);
         end
         if (i_Wr_En && r_Full) begin
            r_Overflow <= 1'b1;
         end
         r_Count <= w_Count_Next;
         r_Full  <= (w_Count_Next == c_DEPTH);
         r_Empty <= (w_Count_Next == '0);
      end
   end

   always_ff @(posedge i_Clock or posedge rst) begin
      if (rst) begin
         r_State      <= c_ST_IDLE;
         r_Phase      <= c_PH_HDR;
         r_Len        <= 8'h00;
         r_Remain     <= 8'h00;
         r_Csum       <= 8'h00;
         r_Tx_DV      <= 1'b0;
         r_Tx_Byte    <= 8'h00;
         r_Busy       <= 1'b0;
         r_Frame_Done <= 1'b0;
      end else begin
         r_Tx_DV      <= 1'b0;
         r_Frame_Done <= 1'b0;
         case (r_State)
            c_ST_IDLE: begin
               if (i_Send) begin
                  r_State  <= c_ST_ISSUE;
                  r_Phase  <= c_PH_HDR;
                  r_Len    <= w_Occ;
                  r_Remain <= w_Occ;
                  r_Csum   <= w_Occ;
                  r_Busy   <= 1'b1;
               end
            end
            c_ST_ISSUE: begin
               if (!i_Tx_Active) begin
                  r_Tx_DV <= 1'b1;
                  r_State <= c_ST_WAIT;
                  case (r_Phase)
                     c_PH_HDR:  r_Tx_Byte <= HEADER;
                     c_PH_LEN:  r_Tx_Byte <= r_Len;
                     c_PH_DATA: begin
                        r_Tx_Byte <= w_Rd_Data;
                        r_Csum    <= r_Csum ^ w_Rd_Data;
                        r_Remain  <= r_Remain - 8'd1;
                     end
                     default:   r_Tx_Byte <= r_Csum;
                  endcase
               end
            end
            c_ST_WAIT: begin
               if (i_Tx_Done) begin
                  r_State <= c_ST_ISSUE;
                  case (r_Phase)
                     c_PH_HDR:  r_Phase <= c_PH_LEN;
                     c_PH_LEN:  r_Phase <= (r_Len != 8'h00) ? c_PH_DATA : c_PH_CSUM;
                     // r_Remain already counts the byte just issued
                     c_PH_DATA: r_Phase <= (r_Remain == 8'h00) ? c_PH_CSUM : c_PH_DATA;
                     default: begin
                        r_State      <= c_ST_IDLE;
                        r_Phase      <= c_PH_HDR;
                        r_Busy       <= 1'b0;
                        r_Frame_Done <= 1'b1;
                     end
                  endcase
               end
            end
            default: begin
               r_State <= c_ST_IDLE;
               r_Phase <= c_PH_HDR;
               r_Busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_Tx_DV      = r_Tx_DV;
   assign o_Tx_Byte    = r_Tx_Byte;
   assign o_Full       = r_Full;
   assign o_Empty      = r_Empty;
   assign o_Busy       = r_Busy;
   assign o_Frame_Done = r_Frame_Done;
   assign o_Overflow   = r_Overflow;

endmodule
`default_nettype wire

// File: tb/tb_mbo_uart_tx_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mbo_uart_tx_framer
//  Function : Directed bench with a queue-based frame model and a UART model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mbo_uart_tx_framer;

   localparam int         ADDR_W       = 2;
   localparam int         DEPTH        = 1 << ADDR_W;
   localparam int         CLKS_PER_BIT = 4;
   localparam logic [7:0] HDR          = 8'hA5;

   logic       i_Clock   = 1'b0;
   logic       rst       = 1'b1;
   logic       i_Wr_En   = 1'b0;
   logic [7:0] i_Wr_Data = 8'h00;
   logic       i_Send    = 1'b0;
   logic       i_Tx_Active;
   logic       i_Tx_Done = 1'b0;
   logic       o_Tx_DV;
   logic [7:0] o_Tx_Byte;
   logic       o_Full, o_Empty, o_Busy, o_Frame_Done, o_Overflow;

   logic       uart_active = 1'b0;
   logic       bp_hold     = 1'b0;
   int         uart_cnt    = 0;

   assign i_Tx_Active = uart_active | bp_hold;

   mbo_uart_tx_framer #(.ADDR_W(ADDR_W), .HEADER(HDR)) dut (
      .i_Clock      (i_Clock),
      .rst          (rst),
      .i_Wr_En      (i_Wr_En),
      .i_Wr_Data    (i_Wr_Data),
      .i_Send       (i_Send),
      .i_Tx_Active  (i_Tx_Active),
      .i_Tx_Done    (i_Tx_Done),
      .o_Tx_DV      (o_Tx_DV),
      .o_Tx_Byte    (o_Tx_Byte),
      .o_Full       (o_Full),
      .o_Empty      (o_Empty),
      .o_Busy       (o_Busy),
      .o_Frame_Done (o_Frame_Done),
      .o_Overflow   (o_Overflow)
   );

   always #5 i_Clock = ~i_Clock;

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // UART transmitter: 10 bit times per byte, Done pulses as Active drops.
   always @(negedge i_Clock) begin
      i_Tx_Done = 1'b0;
      if (uart_active) begin
         if (uart_cnt <= 1) begin
            uart_active = 1'b0;
            i_Tx_Done   = 1'b1;
         end else begin
            uart_cnt--;
         end
      end else if (o_Tx_DV) begin
         uart_active = 1'b1;
         uart_cnt    = CLKS_PER_BIT * 10;
      end
   end

   // Inputs as seen by the DUT at the rising edge.
   logic       p_rst, p_wr, p_send, p_active, p_done;
   logic [7:0] p_data;
   always @(posedge i_Clock) begin
      p_rst    = rst;
      p_wr     = i_Wr_En;
      p_data   = i_Wr_Data;
      p_send   = i_Send;
      p_active = i_Tx_Active;
      p_done   = i_Tx_Done;
   end

   // Model: mq = FIFO contents, fq = bytes of the current frame still to go.
   logic [7:0] mq [$];
   logic [7:0] fq [$];
   logic [7:0] got [$];
   bit         m_busy = 0, m_ready = 0, m_ovf = 0;
   int         m_idx = 0, m_len = 0, sz_before = 0;
   bit         busy_before, exp_dv, exp_done;
   logic [7:0] eb, cs;

   always @(negedge i_Clock) begin
      if (rst || p_rst) begin
         mq.delete();
         fq.delete();
         m_busy  = 0;
         m_ready = 0;
         m_ovf   = 0;
         chk("rst_dv",    o_Tx_DV,      0);
         chk("rst_byte",  o_Tx_Byte,    0);
         chk("rst_busy",  o_Busy,       0);
         chk("rst_done",  o_Frame_Done, 0);
         chk("rst_ovf",   o_Overflow,   0);
         chk("rst_full",  o_Full,       0);
         chk("rst_empty", o_Empty,      1);
      end else begin
         sz_before   = mq.size();
         busy_before = m_busy;
         exp_done    = 0;
         exp_dv      = m_busy && m_ready && !p_active;
         chk("dv", o_Tx_DV, exp_dv);
         if (exp_dv) begin
            eb = fq.pop_front();
            chk("tx_byte", o_Tx_Byte, eb);
            if (m_idx >= 2 && m_idx < 2 + m_len) void'(mq.pop_front());
            m_idx++;
            m_ready = 0;
         end else if (m_busy && !m_ready && p_done) begin
            if (fq.size() == 0) begin
               m_busy   = 0;
               exp_done = 1;
            end else begin
               m_ready = 1;
            end
         end
         if (o_Tx_DV) got.push_back(o_Tx_Byte);
         if (!busy_before && p_send) begin
            m_len = sz_before;
            cs    = 8'(m_len);
            fq.delete();
            fq.push_back(HDR);
            fq.push_back(8'(m_len));
            for (int i = 0; i < m_len; i++) begin
               fq.push_back(mq[i]);
               cs = cs ^ mq[i];
            end
            fq.push_back(cs);
            m_idx   = 0;
            m_busy  = 1;
            m_ready = 1;
         end
         if (p_wr) begin
            if (sz_before == DEPTH) m_ovf = 1;
            else mq.push_back(p_data);
         end
         chk("frame_done", o_Frame_Done, exp_done);
         chk("busy",       o_Busy,       m_busy);
         chk("full",       o_Full,       mq.size() == DEPTH);
         chk("empty",      o_Empty,      mq.size() == 0);
         chk("overflow",   o_Overflow,   m_ovf);
      end
   end

   task automatic wr(input logic [7:0] d);
      @(negedge i_Clock);
      i_Wr_En   = 1'b1;
      i_Wr_Data = d;
      @(negedge i_Clock);
      i_Wr_En   = 1'b0;
   endtask

   task automatic send();
      @(negedge i_Clock);
      i_Send = 1'b1;
      @(negedge i_Clock);
      i_Send = 1'b0;
   endtask

   task automatic wait_frame(input string name);
      bit seen = 0;
      for (int k = 0; k < 3000 && !seen; k++) begin
         @(negedge i_Clock);
         if (o_Frame_Done) seen = 1;
      end
      chk({name, "_frame_done_seen"}, seen, 1);
   endtask

   // Literal frame expectations, independent of the model.
   task automatic check_frame(input string name, input int base, input int n,
                              input logic [7:0] e [0:7]);
      chk({name, "_nbytes"}, got.size() - base, n);
      for (int i = 0; i < n; i++) begin
         if (base + i < got.size()) chk({name, "_byte"}, got[base + i], e[i]);
      end
   endtask

   int base;

   initial begin
      repeat (3) @(posedge i_Clock);
      #2 rst = 1'b0;
      @(negedge i_Clock);
      chk("init_empty", o_Empty, 1);
      chk("init_full",  o_Full,  0);
      chk("init_busy",  o_Busy,  0);

      // Basic frame
      base = got.size();
      wr(8'h11); wr(8'h22); wr(8'h33);
      chk("basic_empty_before", o_Empty, 0);
      send();
      wait_frame("basic");
      check_frame("basic", base, 6, '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'h00, 8'h00});
      chk("basic_empty_after", o_Empty, 1);

      // Empty send
      base = got.size();
      send();
      wait_frame("empty");
      check_frame("empty", base, 3, '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

      // Overflow and wrap
      wr(8'h01); wr(8'h02); wr(8'h03);
      chk("ovf_full_after3", o_Full, 0);
      wr(8'h04);
      chk("ovf_full_after4", o_Full, 1);
      chk("ovf_flag_before", o_Overflow, 0);
      wr(8'h05);
      chk("ovf_flag_after", o_Overflow, 1);
      base = got.size();
      send();
      wait_frame("ovf");
      check_frame("ovf", base, 7, '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00});
      wr(8'h06); wr(8'h07);
      base = got.size();
      send();
      wait_frame("wrap");
      check_frame("wrap", base, 5, '{8'hA5, 8'h02, 8'h06, 8'h07, 8'h03, 8'h00, 8'h00, 8'h00});

      // Writes during a frame stay queued
      wr(8'h10); wr(8'h20);
      base = got.size();
      send();
      repeat (60) @(negedge i_Clock);
      wr(8'hEE);
      wait_frame("midwr1");
      check_frame("midwr1", base, 5, '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32, 8'h00, 8'h00, 8'h00});
      base = got.size();
      send();
      wait_frame("midwr2");
      check_frame("midwr2", base, 4, '{8'hA5, 8'h01, 8'hEE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00});

      // Backpressure, plus a second send while busy
      wr(8'h5A);
      base = got.size();
      @(negedge i_Clock);
      bp_hold = 1'b1;
      send();
      for (int i = 0; i < 20; i++) begin
         @(negedge i_Clock);
         i_Send = (i == 8);
         chk("bp_no_dv", o_Tx_DV, 0);
      end
      i_Send = 1'b0;
      chk("bp_busy", o_Busy, 1);
      bp_hold = 1'b0;
      @(negedge i_Clock);
      chk("bp_hdr_dv", o_Tx_DV, 1);
      chk("bp_hdr_byte", o_Tx_Byte, 8'hA5);
      wait_frame("bp");
      check_frame("bp", base, 4, '{8'hA5, 8'h01, 8'h5A, 8'h5B, 8'h00, 8'h00, 8'h00, 8'h00});
      repeat (5) @(negedge i_Clock);
      chk("bp_idle_after", o_Busy, 0);

      // Reset mid-frame
      wr(8'h71); wr(8'h72); wr(8'h73);
      base = got.size();
      send();
      for (int k = 0; k < 500 && got.size() < base + 3; k++) @(negedge i_Clock);
      chk("mid_reached_data", got.size() >= base + 3, 1);
      @(posedge i_Clock);
      #2 rst = 1'b1;
      @(negedge i_Clock);
      chk("midrst_busy",  o_Busy,    0);
      chk("midrst_empty", o_Empty,   1);
      chk("midrst_dv",    o_Tx_DV,   0);
      chk("midrst_byte",  o_Tx_Byte, 0);
      @(posedge i_Clock);
      #2 rst = 1'b0;
      for (int k = 0; k < 500 && uart_active; k++) @(negedge i_Clock);
      repeat (3) @(negedge i_Clock);
      base = got.size();
      wr(8'h81);
      send();
      wait_frame("postrst");
      check_frame("postrst", base, 4, '{8'hA5, 8'h01, 8'h81, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00});

      repeat (5) @(negedge i_Clock);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
